// File: rtl/spart_bus_if.sv
// Processor-side bus interface for the SPART: divisor registers, baud tick
// generator, one-byte transmit buffer and one-byte receive buffer with status.
module spart_bus_if #(
  parameter logic [15:0] DIV_RST = 16'h28B1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       baud_en,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid
);

  logic [15:0] div;
  logic [15:0] cnt;
  logic [15:0] div_eff;
  logic        reload;
  logic        ovr;
  logic [7:0]  tx_buf;
  logic [7:0]  rx_buf;
  logic [7:0]  rdata;
  logic        rd_buf;
  logic        rd_stat;
  logic        wr_buf;
  logic        wr_lo;
  logic        wr_hi;
  logic        ovr_set;

  always_comb begin
    rd_buf  = iocs && iorw && (ioaddr == 2'b00);
    rd_stat = iocs && iorw && (ioaddr == 2'b01);
    wr_buf  = iocs && !iorw && (ioaddr == 2'b00);
    wr_lo   = iocs && !iorw && (ioaddr == 2'b10);
    wr_hi   = iocs && !iorw && (ioaddr == 2'b11);
    // A byte landing while an older one is still unread is an overrun,
    // except when the CPU is draining the buffer in that very cycle.
    ovr_set = rx_valid && rda && !rd_buf;
    div_eff = (div == 16'd0) ? 16'd1 : div;
  end

  // reload comes out of reset set, so the first edge after release loads DIV_RST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= DIV_RST;
      cnt    <= DIV_RST;
      reload <= 1'b1;
    end else begin
      if (wr_lo) div[7:0]  <= databus;
      if (wr_hi) div[15:8] <= databus;
      reload <= wr_hi;
      if (reload || (cnt <= 16'd1)) cnt <= div_eff;
      else                          cnt <= cnt - 16'd1;
    end
  end

  assign baud_en = !rst && (cnt == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf   <= 8'h00;
      tx_valid <= 1'b0;
    end else if (wr_buf && !tx_valid) begin
      tx_buf   <= databus;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  assign tbr     = !tx_valid;
  assign tx_data = tx_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf <= 8'h00;
      rda    <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (rx_valid) begin
        rx_buf <= rx_byte;
        rda    <= 1'b1;
      end else if (rd_buf) begin
        rda    <= 1'b0;
      end
      if (ovr_set)      ovr <= 1'b1;
      else if (rd_stat) ovr <= 1'b0;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00: rdata = rx_buf;
      2'b01: rdata = {5'b00000, ovr, tbr, rda};
      2'b10: rdata = div[7:0];
      2'b11: rdata = div[15:8];
      default: rdata = 8'h00;
    endcase
  end

  assign databus = (iocs && iorw && !rst) ? rdata : 8'bz;

endmodule

// File: tb/tb_spart_bus_if.sv
// Bench for spart_bus_if: a register-level model checked every cycle plus
// directed scenarios with literal expected values.
module tb_spart_bus_if;
  localparam logic [15:0] DIV_RST = 16'h28B1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] drv = 8'h00;
  logic       drv_en;
  wire  [7:0] databus;
  logic       rda, tbr, baud_en, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign drv_en  = iocs && !iorw;
  assign databus = drv_en ? drv : 8'bz;
  // Pull-ups make an undriven bus read as 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (databus[g]);
  end

  spart_bus_if #(.DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .baud_en(baud_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register contents plus the absolute edge number of the next tick.
  logic [15:0] m_div;
  logic [7:0]  m_txbuf, m_rxbuf;
  logic        m_txv, m_rda, m_ovr, m_be;
  int          n = 0;
  int          next_tick = 0;

  function automatic int eff(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'b00:   return m_rxbuf;
      2'b01:   return {5'b00000, m_ovr, !m_txv, m_rda};
      2'b10:   return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  task automatic m_reset();
    m_div = DIV_RST; m_txbuf = 8'h00; m_rxbuf = 8'h00;
    m_txv = 1'b0; m_rda = 1'b0; m_ovr = 1'b0; m_be = 1'b0;
    next_tick = n + eff(DIV_RST);
  endtask

  task automatic m_edge();
    logic        rd0, rd1, wr;
    logic [7:0]  d;
    logic [15:0] nd;
    logic        set_ovr;
    rd0 = iocs && iorw && (ioaddr == 2'b00);
    rd1 = iocs && iorw && (ioaddr == 2'b01);
    wr  = iocs && !iorw;
    d   = databus;
    n++;
    m_be = (n == next_tick);
    nd = m_div;
    if (wr && ioaddr == 2'b10) nd[7:0]  = d;
    if (wr && ioaddr == 2'b11) nd[15:8] = d;
    // After a tick or a DB-high write the next tick is one full divisor away.
    if ((wr && ioaddr == 2'b11) || m_be) next_tick = n + eff(nd);
    m_div = nd;
    if (wr && ioaddr == 2'b00 && !m_txv) begin
      m_txbuf = d; m_txv = 1'b1;
    end else if (m_txv && tx_ready) begin
      m_txv = 1'b0;
    end
    set_ovr = rx_valid && m_rda && !rd0;
    if (rx_valid) begin
      m_rxbuf = rx_byte; m_rda = 1'b1;
    end else if (rd0) begin
      m_rda = 1'b0;
    end
    if (set_ovr)  m_ovr = 1'b1;
    else if (rd1) m_ovr = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check1("cmp_baud_en", baud_en, m_be);
      check1("cmp_tbr", tbr, !m_txv);
      check1("cmp_tx_valid", tx_valid, m_txv);
      check8("cmp_tx_data", tx_data, m_txbuf);
      check1("cmp_rda", rda, m_rda);
      if (iocs && iorw && !rst) check8("cmp_bus_read", databus, m_read(ioaddr));
      else if (!drv_en)         check8("cmp_bus_idle", databus, 8'hFF);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = v;
    @(posedge clk); #1;
    iocs = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 v = databus;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int exp, input int bound);
    int k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      k++;
      if (baud_en || k >= bound) break;
    end
    check1({name, "_seen"}, baud_en, 1'b1);
    check_int(name, k, exp);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    check8(name, v, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    step(3);
    check1("rst_tbr", tbr, 1'b1);
    check1("rst_rda", rda, 1'b0);
    check1("rst_tx_valid", tx_valid, 1'b0);
    check1("rst_baud_en", baud_en, 1'b0);
    check8("rst_tx_data", tx_data, 8'h00);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10;
    #1 check8("rst_bus_z_on_read", databus, 8'hFF);
    iocs = 1'b0; iorw = 1'b0;
    step(1);
    rst = 1'b0;

    rd_check("div_lo_reset", 2'b10, 8'hB1);
    rd_check("div_hi_reset", 2'b11, 8'h28);
    rd_check("status_reset", 2'b01, 8'h02);

    wr(2'b10, 8'h16);
    wr(2'b11, 8'h05);
    wait_tick("baud_first", 1302, 1400);
    wait_tick("baud_period", 1302, 1400);
    rd_check("div_lo_rb", 2'b10, 8'h16);
    rd_check("div_hi_rb", 2'b11, 8'h05);

    wr(2'b10, 8'h00);
    wr(2'b11, 8'h00);
    wait_tick("baud_div0", 1, 5);
    step(1); check1("baud_div0_c1", baud_en, 1'b1);
    step(1); check1("baud_div0_c2", baud_en, 1'b1);
    wr(2'b10, 8'h16);
    wr(2'b11, 8'h05);

    tx_ready = 1'b0;
    wr(2'b00, 8'hA5);
    step(5);
    check1("tx_tbr_busy", tbr, 1'b0);
    check1("tx_valid_held", tx_valid, 1'b1);
    check8("tx_data_held", tx_data, 8'hA5);
    wr(2'b00, 8'h3C);
    check8("tx_ignored_write", tx_data, 8'hA5);
    check1("tx_valid_still", tx_valid, 1'b1);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    check1("tx_tbr_free", tbr, 1'b1);
    check1("tx_valid_clr", tx_valid, 1'b0);

    rx(8'h41);
    check1("rx_rda_set", rda, 1'b1);
    rd_check("rx_read_41", 2'b00, 8'h41);
    check1("rx_rda_clr", rda, 1'b0);
    rd_check("rx_status_02", 2'b01, 8'h02);

    rx(8'h11);
    rx(8'h22);
    rd_check("ovr_status_07", 2'b01, 8'h07);
    rd_check("ovr_status_03", 2'b01, 8'h03);
    rd_check("ovr_rxbuf_22", 2'b00, 8'h22);
    rd_check("ovr_status_02", 2'b01, 8'h02);

    rx(8'h44);
    rx_valid = 1'b1; rx_byte = 8'h55;
    rd(2'b00, v);
    rx_valid = 1'b0;
    check8("coinc_old_byte", v, 8'h44);
    check1("coinc_rda_kept", rda, 1'b1);
    rd_check("coinc_status_03", 2'b01, 8'h03);
    rd_check("coinc_rxbuf_55", 2'b00, 8'h55);

    rx(8'h66);
    rx_valid = 1'b1; rx_byte = 8'h67;
    rd(2'b01, v);
    rx_valid = 1'b0;
    check8("ovr_prio_old", v, 8'h03);
    rd_check("ovr_prio_set", 2'b01, 8'h07);
    rd_check("ovr_prio_clr", 2'b01, 8'h03);
    rd_check("ovr_prio_buf", 2'b00, 8'h67);

    wr(2'b01, 8'hFF);
    rd_check("status_wr_ignored", 2'b01, 8'h02);
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b11; drv = 8'h00;
    step(2);
    rd_check("nocs_div_hi", 2'b11, 8'h05);

    wr(2'b00, 8'h5A);
    rx(8'h77);
    check1("pre_rst_tx_valid", tx_valid, 1'b1);
    check1("pre_rst_rda", rda, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("mid_rst_tbr", tbr, 1'b1);
    check1("mid_rst_tx_valid", tx_valid, 1'b0);
    check1("mid_rst_rda", rda, 1'b0);
    check1("mid_rst_baud_en", baud_en, 1'b0);
    check8("mid_rst_tx_data", tx_data, 8'h00);
    check8("mid_rst_bus", databus, 8'hFF);
    step(2);
    rst = 1'b0;
    wait_tick("baud_after_rst", int'(DIV_RST), int'(DIV_RST) + 100);
    check1("post_rst_tx_valid", tx_valid, 1'b0);
    rd_check("post_rst_status", 2'b01, 8'h02);
    rd_check("post_rst_div_lo", 2'b10, 8'hB1);
    rd_check("post_rst_rxbuf", 2'b00, 8'h00);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
